// File: rtl/hit_edge_motion_ctrl.sv
// Hit-edge driven object motion: collects bitmap edge hits per frame, bounces the velocity, advances a clamped fixed-point position.
// Optional gravity on the Y velocity is enabled by defining HIT_EDGE_MOTION_GRAVITY_EN.
module hit_edge_motion_ctrl #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = -20,
  parameter int MAX_X           = 575,
  parameter int MAX_Y           = 447,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_Y_SPEED     = 240
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        frameHit,
  output logic        moveDone
);

  localparam int FRAC_BITS = 6;
  localparam logic signed [17:0] RESET_X_FP = 18'(INITIAL_X * 64);
  localparam logic signed [17:0] RESET_Y_FP = 18'(INITIAL_Y * 64);
  localparam logic signed [10:0] RESET_VX   = 11'(INITIAL_X_SPEED);
  localparam logic signed [10:0] RESET_VY   = 11'(INITIAL_Y_SPEED);
  localparam logic signed [18:0] LIMIT_X_FP = 19'(MAX_X * 64);
  localparam logic signed [18:0] LIMIT_Y_FP = 19'(MAX_Y * 64);

  // Gravity settings must describe a downward pull whose limit fits an 11-bit signed velocity.
  if (Y_ACCEL < 0 || MAX_Y_SPEED <= 0 || MAX_Y_SPEED > 1023) begin : gBadGravityCfg
    $error("hit_edge_motion_ctrl: gravity parameters out of range");
  end

  typedef enum logic [1:0] {
    FRAME_WAIT = 2'd0,
    RESOLVE    = 2'd1,
    MOVE       = 2'd2
  } state_t;

  // HitEdgeCode bit order is {Left, Top, Right, Bottom}.
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  state_t             state_q, state_d;
  logic [3:0]         hitAcc_q, hitAcc_d;
  logic [3:0]         hitSnap_q, hitSnap_d;
  logic signed [17:0] posX_q, posX_d;
  logic signed [17:0] posY_q, posY_d;
  logic signed [10:0] velX_q, velX_d;
  logic signed [10:0] velY_q, velY_d;
  logic [10:0]        topLeftX_q, topLeftY_q;
  logic               frameHit_q, frameHit_d;
  logic               moveDone_q, moveDone_d;

  logic signed [10:0] velYMove;
  logic signed [18:0] sumX, sumY;

`ifdef HIT_EDGE_MOTION_GRAVITY_EN
  logic signed [11:0] velYAccel;
  always_comb begin
    velYAccel = {velY_q[10], velY_q} + 12'(Y_ACCEL);
    if (velYAccel > 12'(MAX_Y_SPEED)) begin
      velYMove = 11'(MAX_Y_SPEED);
    end else begin
      velYMove = velYAccel[10:0];
    end
  end
`else
  assign velYMove = velY_q;
`endif

  // Position sums are one bit wider so the clamp sees true negatives and overshoots.
  assign sumX = {posX_q[17], posX_q} + 19'(velX_q);
  assign sumY = {posY_q[17], posY_q} + 19'(velYMove);

  always_comb begin
    state_d    = state_q;
    hitSnap_d  = hitSnap_q;
    posX_d     = posX_q;
    posY_d     = posY_q;
    velX_d     = velX_q;
    velY_d     = velY_q;
    frameHit_d = 1'b0;
    moveDone_d = 1'b0;
    hitAcc_d   = collision ? (hitAcc_q | HitEdgeCode) : hitAcc_q;

    case (state_q)
      FRAME_WAIT: begin
        if (startOfFrame) begin
          hitSnap_d = hitAcc_q;
          hitAcc_d  = collision ? HitEdgeCode : 4'd0;
          state_d   = RESOLVE;
        end
      end

      RESOLVE: begin
        // Only bounce when heading into the struck edge, so opposing hits reverse once.
        if ((hitSnap_q[EDGE_LEFT] && velX_q < 0) || (hitSnap_q[EDGE_RIGHT] && velX_q > 0)) begin
          velX_d = -velX_q;
        end
        if ((hitSnap_q[EDGE_TOP] && velY_q < 0) || (hitSnap_q[EDGE_BOTTOM] && velY_q > 0)) begin
          velY_d = -velY_q;
        end
        state_d = MOVE;
      end

      MOVE: begin
        velY_d = velYMove;
        if (sumX < 0) begin
          posX_d = '0;
        end else if (sumX > LIMIT_X_FP) begin
          posX_d = LIMIT_X_FP[17:0];
        end else begin
          posX_d = sumX[17:0];
        end
        if (sumY < 0) begin
          posY_d = '0;
        end else if (sumY > LIMIT_Y_FP) begin
          posY_d = LIMIT_Y_FP[17:0];
        end else begin
          posY_d = sumY[17:0];
        end
        frameHit_d = (hitSnap_q != 4'd0);
        moveDone_d = 1'b1;
        state_d    = FRAME_WAIT;
      end

      default: begin
        state_d = FRAME_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= FRAME_WAIT;
      hitAcc_q   <= '0;
      hitSnap_q  <= '0;
      posX_q     <= RESET_X_FP;
      posY_q     <= RESET_Y_FP;
      velX_q     <= RESET_VX;
      velY_q     <= RESET_VY;
      topLeftX_q <= 11'(INITIAL_X);
      topLeftY_q <= 11'(INITIAL_Y);
      frameHit_q <= 1'b0;
      moveDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hitAcc_q   <= hitAcc_d;
      hitSnap_q  <= hitSnap_d;
      posX_q     <= posX_d;
      posY_q     <= posY_d;
      velX_q     <= velX_d;
      velY_q     <= velY_d;
      topLeftX_q <= 11'(posX_q >>> FRAC_BITS);
      topLeftY_q <= 11'(posY_q >>> FRAC_BITS);
      frameHit_q <= frameHit_d;
      moveDone_q <= moveDone_d;
    end
  end

  assign topLeftX = topLeftX_q;
  assign topLeftY = topLeftY_q;
  assign frameHit = frameHit_q;
  assign moveDone = moveDone_q;

endmodule

// File: tb/tb_hit_edge_motion_ctrl.sv
// Directed bench for hit_edge_motion_ctrl: a default-parameter instance plus a near-corner instance that exercises clamping.
module tb_hit_edge_motion_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic        collisionB;
  logic [3:0]  hitEdgeCodeB;
  logic [10:0] topLeftX, topLeftY, topLeftXB, topLeftYB;
  logic        frameHit, moveDone, frameHitB, moveDoneB;

  int compared   = 0;
  int mismatched = 0;

  hit_edge_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .collision(collision), .HitEdgeCode(HitEdgeCode),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .frameHit(frameHit), .moveDone(moveDone)
  );

  // Starts one pixel from the top and near the right limit, moving up fast.
  hit_edge_motion_ctrl #(
    .INITIAL_X(574), .INITIAL_Y(1), .INITIAL_X_SPEED(40), .INITIAL_Y_SPEED(-100)
  ) dutB (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .collision(collisionB), .HitEdgeCode(hitEdgeCodeB),
    .topLeftX(topLeftXB), .topLeftY(topLeftYB),
    .frameHit(frameHitB), .moveDone(moveDoneB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // One frame: optional hits before startOfFrame, startOfFrame held sofLen cycles, then check outputs.
  task automatic applyStimulus(input string tag, input logic [3:0] codeA, input bit hitBefore,
                               input bit hitAtSof, input logic [3:0] codeB, input int sofLen,
                               input int expX, input int expY, input int expHit,
                               input int expXB, input int expYB, input int expHitB);
    @(negedge clk);
    if (hitBefore || codeB != 4'd0) begin
      collision    = hitBefore;
      HitEdgeCode  = codeA;
      collisionB   = (codeB != 4'd0);
      hitEdgeCodeB = codeB;
      @(negedge clk);
      collision  = 1'b0;
      collisionB = 1'b0;
    end
    startOfFrame = 1'b1;
    if (hitAtSof) begin
      collision   = 1'b1;
      HitEdgeCode = codeA;
    end
    @(negedge clk);
    collision = 1'b0;
    if (sofLen <= 1) startOfFrame = 1'b0;
    @(negedge clk);
    if (sofLen <= 2) startOfFrame = 1'b0;
    @(negedge clk);
    startOfFrame = 1'b0;
    checkOutput({tag, " moveDone"}, 32'(moveDone), 1);
    checkOutput({tag, " frameHit"}, 32'(frameHit), expHit);
    checkOutput({tag, " B frameHit"}, 32'(frameHitB), expHitB);
    @(negedge clk);
    checkOutput({tag, " topLeftX"}, 32'($signed(topLeftX)), expX);
    checkOutput({tag, " topLeftY"}, 32'($signed(topLeftY)), expY);
    checkOutput({tag, " moveDone low"}, 32'(moveDone), 0);
    checkOutput({tag, " B topLeftX"}, 32'($signed(topLeftXB)), expXB);
    checkOutput({tag, " B topLeftY"}, 32'($signed(topLeftYB)), expYB);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    collision    = 1'b0;
    HitEdgeCode  = 4'd0;
    collisionB   = 1'b0;
    hitEdgeCodeB = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset topLeftX", 32'($signed(topLeftX)), 280);
    checkOutput("reset topLeftY", 32'($signed(topLeftY)), 185);
    checkOutput("reset frameHit", 32'(frameHit), 0);
    checkOutput("reset moveDone", 32'(moveDone), 0);
    checkOutput("reset B topLeftX", 32'($signed(topLeftXB)), 574);
    checkOutput("reset B topLeftY", 32'($signed(topLeftYB)), 1);
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("idle topLeftY", 32'($signed(topLeftY)), 185);

    //             tag    codeA  bef  sof  codeB len  X    Y    hit  XB   YB  hitB
    applyStimulus("f1",  4'h0, 1'b0, 1'b0, 4'h0, 1, 280, 184, 0, 574,  0, 0);
    applyStimulus("f2",  4'h2, 1'b1, 1'b0, 4'h0, 1, 280, 184, 1, 575,  0, 0);
    applyStimulus("f3",  4'h0, 1'b0, 1'b0, 4'h0, 3, 279, 184, 0, 575,  0, 0);
    applyStimulus("f4",  4'h2, 1'b1, 1'b0, 4'h4, 1, 278, 183, 1, 575,  1, 1);
    applyStimulus("f5",  4'h8, 1'b1, 1'b0, 4'h0, 1, 279, 183, 1, 575,  3, 0);
    applyStimulus("f6",  4'h8, 1'b1, 1'b0, 4'h0, 2, 280, 183, 1, 575,  4, 0);
    applyStimulus("f7",  4'h1, 1'b0, 1'b1, 4'h0, 1, 280, 182, 0, 575,  6, 0);
    applyStimulus("f8",  4'h0, 1'b0, 1'b0, 4'h0, 1, 281, 182, 1, 575,  7, 0);
    applyStimulus("f9",  4'h4, 1'b1, 1'b0, 4'h0, 1, 281, 182, 1, 575,  9, 0);
    applyStimulus("f10", 4'h1, 1'b1, 1'b0, 4'h0, 1, 282, 182, 1, 575, 10, 0);
    applyStimulus("f11", 4'hA, 1'b1, 1'b0, 4'h0, 1, 281, 182, 1, 575, 12, 0);
    applyStimulus("f12", 4'h5, 1'b1, 1'b0, 4'h0, 1, 281, 182, 1, 575, 14, 0);

    // Abort a frame in MOVE with a pending hit; everything must return to reset values at once.
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    collision    = 1'b1;
    HitEdgeCode  = 4'h2;
    @(negedge clk);
    collision = 1'b0;
    resetN    = 1'b0;
    #1;
    checkOutput("abort topLeftX", 32'($signed(topLeftX)), 280);
    checkOutput("abort topLeftY", 32'($signed(topLeftY)), 185);
    checkOutput("abort moveDone", 32'(moveDone), 0);
    checkOutput("abort B topLeftY", 32'($signed(topLeftYB)), 1);
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus("post", 4'h0, 1'b0, 1'b0, 4'h0, 1, 280, 184, 0, 574, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hit_edge_motion_ctrl.md
Name: hit_edge_motion_ctrl

Overview:
- Consumer end of the bitmap hit-edge interface. The bitmap block emits HitEdgeCode and drawingRequest per pixel; this block turns those into object motion.
- During each frame it ORs together the hit-edge codes seen on collision pixels. At frame start it reverses velocity toward each hit edge, then advances the object's top-left position in fixed point.
- Its outputs topLeftX/topLeftY feed the rectangle/offset logic that drives the bitmap.

Parameters:
- INITIAL_X, 280, reset top-left X in pixels.
- INITIAL_Y, 185, reset top-left Y in pixels.
- INITIAL_X_SPEED, 40, reset X velocity, signed, in 1/64 pixel per frame.
- INITIAL_Y_SPEED, -20, reset Y velocity, signed, in 1/64 pixel per frame.
- MAX_X, 575, upper clamp for topLeftX in pixels.
- MAX_Y, 447, upper clamp for topLeftY in pixels.
- Y_ACCEL, 1, Y velocity increment per frame; used only with GRAVITY_EN.
- MAX_Y_SPEED, 240, magnitude limit on Y velocity; used only with GRAVITY_EN.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle pulse at the start of each VGA frame.
- collision  in  1  this pixel is a collision: object drawingRequest AND another object's drawingRequest.
- HitEdgeCode  in  4  {Left,Top,Right,Bottom}, from the bitmap; valid when collision=1.
- topLeftX  out  11  signed object X, in pixels.
- topLeftY  out  11  signed object Y, in pixels.
- frameHit  out  1  one-cycle pulse in MOVE when the resolved frame had any hit.
- moveDone  out  1  one-cycle pulse when the position update completes.

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk. Reset values:
  - posX_fp = INITIAL_X*64; posY_fp = INITIAL_Y*64; both 18-bit signed, 6 fraction bits.
  - velX = INITIAL_X_SPEED; velY = INITIAL_Y_SPEED; both 11-bit signed.
  - hit_acc = 0; hit_snap = 0; state = FRAME_WAIT.
  - topLeftX = INITIAL_X; topLeftY = INITIAL_Y; frameHit = 0; moveDone = 0.
- topLeftX/topLeftY are registered as posX_fp>>>6 and posY_fp>>>6 (arithmetic shift) and update in the cycle after MOVE.
- Accumulation, in every state: if collision=1, hit_acc |= HitEdgeCode.
- FRAME_WAIT on startOfFrame=1:
  - hit_snap <= hit_acc;
  - hit_acc <= collision ? HitEdgeCode : 0, so a same-cycle hit is counted in the new frame;
  - next state RESOLVE.
- RESOLVE, 1 cycle. Each reversal applies only when moving toward that edge:
  - Left set and velX<0 → velX = -velX.
  - Right set and velX>0 → velX = -velX.
  - Top set and velY<0 → velY = -velY.
  - Bottom set and velY>0 → velY = -velY.
  - Left and Right both set with velX≠0 → exactly one reversal; same rule for Top/Bottom. velX=0 → no change.
  - Next state MOVE.
- MOVE, 1 cycle:
  - posX_fp += sign-extended velX; posY_fp += sign-extended velY.
  - Clamp X to [0, MAX_X*64] and Y to [0, MAX_Y*64]. Clamping does not alter velocity.
  - frameHit = (hit_snap≠0); moveDone = 1; next state FRAME_WAIT.
- startOfFrame seen in RESOLVE or MOVE is ignored; there is no queueing.
- Total latency from startOfFrame to new topLeftX/topLeftY: 3 clk.
- Reset asserted mid-RESOLVE or mid-MOVE aborts the update; all values return to reset values.

Optional Feature:
- Macro: HIT_EDGE_MOTION_GRAVITY_EN.
- Defined: in MOVE, before the position add, velY = min(velY + Y_ACCEL, MAX_Y_SPEED) as a saturating signed add. The position add uses the updated velY.
- Undefined: velY changes only by reversal. Y_ACCEL and MAX_Y_SPEED are unused.

Test Plan:
- Reset, then one startOfFrame with no collisions → after 3 clk: topLeftX=280 (17920+40 → 17960>>>6=280), topLeftY=184; moveDone pulses; frameHit=0.
- Collision with HitEdgeCode=4'h2 (Right) during frame, velX=+40 → next frame velX=-40, frameHit=1, posX_fp decreases by 40.
- Collision with HitEdgeCode=4'h8 (Left) while velX=+40 → velX stays +40, frameHit=1.
- Collision with code 4'h1 in the same cycle as startOfFrame, no other hits → current resolve sees hit_snap=0; the following frame reverses velY only if velY>0.
- posY_fp=64 (Y=1), velY=-100, no hits → topLeftY clamps to 0 and velY stays -100.
- With HIT_EDGE_MOTION_GRAVITY_EN, velY=-20, Y_ACCEL=1, 30 frames with no hits → velY=10; reset asserted mid-MOVE → topLeftY=185 and velY=-20 immediately.
